// File: rtl/sequencer_pkg.sv
// Shared types and constants for the program sequencer: FSM state encoding,
// instruction word layout and the default no-operation opcode.
package sequencer_pkg;

    localparam int INPUT_DATA_WIDTH = 4;
    localparam int WORD_W           = 3 * INPUT_DATA_WIDTH;

    localparam int OPC_MSB = 11;
    localparam int OPC_LSB = 8;
    localparam int OPR_MSB = 7;
    localparam int OPR_LSB = 0;

    localparam logic [INPUT_DATA_WIDTH-1:0] NOP_OPCODE_DEF = 4'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/program_memory.sv
// Program store: 2^AW instruction words, one synchronous write port and one
// synchronous read port. Contents are deliberately not touched by reset.
module program_memory
    import sequencer_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [WORD_W-1:0] rd_data_o
);

    logic [WORD_W-1:0] mem_q [0:(1<<AW)-1];
    logic [WORD_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/program_sequencer.sv
// Fetch/issue controller: walks a program counter through the program store
// and hands each instruction to the execution unit with a one-cycle start.
module program_sequencer
    import sequencer_pkg::*;
#(
    parameter int                          ROM_ADDRESS_WIDTH = 5,
    parameter logic [INPUT_DATA_WIDTH-1:0] NOP_OPCODE        = NOP_OPCODE_DEF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               load_en,
    input  logic [ROM_ADDRESS_WIDTH-1:0]       load_addr,
    input  logic [WORD_W-1:0]                  load_data,
    input  logic                               run,
    input  logic                               step,
    input  logic                               loop,
    input  logic [ROM_ADDRESS_WIDTH-1:0]       end_addr,
    output logic [INPUT_DATA_WIDTH-1:0]        opcode,
    output logic [2*INPUT_DATA_WIDTH-1:0]      operand,
    output logic                               start,
    output logic [ROM_ADDRESS_WIDTH-1:0]       pc,
    output logic                               busy,
    output logic                               done,
    output state_e                             state_o
);

    localparam logic [ROM_ADDRESS_WIDTH-1:0] PC_ONE = {{(ROM_ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    state_e                         state_q, state_d;
    logic [ROM_ADDRESS_WIDTH-1:0]   pc_q, pc_d;
    logic                           single_q, single_d;
    logic                           start_q, busy_q, done_q;
    logic                           mem_wr_en, mem_rd_en;
    logic [WORD_W-1:0]              rd_word;
    logic                           keep_running;

    program_memory #(
        .AW (ROM_ADDRESS_WIDTH)
    ) u_mem (
        .clk_i     (clk),
        .wr_en_i   (mem_wr_en),
        .wr_addr_i (load_addr),
        .wr_data_i (load_data),
        .rd_en_i   (mem_rd_en),
        .rd_addr_i (pc_q),
        .rd_data_o (rd_word)
    );

    assign keep_running = run && !single_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        single_d  = single_q;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        case (state_q)
            IDLE: begin
                mem_wr_en = load_en;
                if (run) begin
                    state_d  = FETCH;
                    single_d = 1'b0;
                end else if (step) begin
                    state_d  = FETCH;
                    single_d = 1'b1;
                end
            end
            FETCH: begin
                mem_rd_en = 1'b1;
                state_d   = ISSUE;
            end
            ISSUE: begin
                single_d = 1'b0;
                if (pc_q == end_addr) begin
                    if (loop) begin
                        pc_d    = '0;
                        state_d = keep_running ? FETCH : IDLE;
                    end else begin
                        state_d = HALT;
                    end
                end else begin
                    // Natural wrap past the top of the store when end_addr is never hit.
                    pc_d    = pc_q + PC_ONE;
                    state_d = keep_running ? FETCH : IDLE;
                end
            end
            HALT: begin
                mem_wr_en = load_en;
                if (!run) begin
                    state_d = IDLE;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            single_q <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            single_q <= single_d;
            start_q  <= (state_d == ISSUE);
            busy_q   <= (state_d == FETCH) || (state_d == ISSUE);
            done_q   <= (state_d == HALT);
        end
    end

    // The execution unit enables its accumulator on opcode alone, so the
    // fetched word is only exposed while start is high.
    assign opcode  = start_q ? rd_word[OPC_MSB:OPC_LSB] : NOP_OPCODE;
    assign operand = start_q ? rd_word[OPR_MSB:OPR_LSB] : '0;
    assign start   = start_q;
    assign pc      = pc_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign state_o = state_q;

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Fetch/issue controller that drives the execution unit from a small writable program store. Holds a 32-entry instruction memory loaded over a simple write port, steps a program counter through it, and presents each instruction's opcode/operand to the execution unit for exactly one cycle with a `start` strobe. Supports free-run, single-step, pause, end-of-program halt and loop-back. Sits between the SPI/host front end and the execution unit.

## Interface
- `ROM_ADDRESS_WIDTH`, 5: program counter / memory address width (depth = 2^W).
- `INPUT_DATA_WIDTH`, 4: opcode width; operand width is 2x this.
- `NOP_OPCODE`, 4'h0: opcode driven whenever no instruction is being issued; must decode to no register, shift or ACC enable.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `load_en` in 1: write strobe for program memory.
- `load_addr` in W: write address.
- `load_data` in 12: instruction word; [11:8] opcode, [7:0] operand.
- `run` in 1: level; high = execute continuously.
- `step` in 1: one-cycle pulse; executes one instruction when paused.
- `loop` in 1: at end address, wrap to 0 instead of halting.
- `end_addr` in W: address of last instruction; sampled when a fetch of that address completes.
- `opcode` out 4: to execution unit.
- `operand` out 8: to execution unit.
- `start` out 1: to execution unit; high only in ISSUE.
- `pc` out W: current program counter.
- `busy` out 1: high in FETCH/ISSUE.
- `done` out 1: high in HALT.

## Operation
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: `run`=1 or `step`=1 -> FETCH (`step` latched as single-shot).
- FETCH: memory read at `pc`; word registered at end of cycle -> ISSUE.
- ISSUE: `opcode`=word[11:8], `operand`=word[7:0], `start`=1 for this cycle only. Next PC: if `pc`==`end_addr` then 0 if `loop` else stay, -> HALT (no loop); otherwise `pc`+1. Then -> FETCH if `run`=1 and not single-shot and not halting; else IDLE.
- HALT: `done`=1; outputs at NOP; `run`=0 -> IDLE with `pc`=0.
- Outside ISSUE: `opcode`=`NOP_OPCODE`, `operand`=0, `start`=0. Required because the execution unit's accumulator enables on opcode alone.
- `run` falling mid-instruction: current FETCH/ISSUE completes, then IDLE with `pc` advanced (pause; resume continues).
- `step` while `run`=1 or busy: ignored.
- `load_en` accepted only in IDLE or HALT; otherwise dropped silently. Write and fetch never collide.
- `pc` wraps 2^W-1 -> 0 if `end_addr` is not reached.
- Memory contents are not cleared by `reset`.

## Timing
- Reset values: state IDLE, `pc`=0, `opcode`=`NOP_OPCODE`, `operand`=0, `start`=0, `busy`=0, `done`=0, single-shot flag 0.
- 2 cycles per instruction in free-run; `start` high every other cycle.
- `run` seen high in IDLE on edge N: FETCH cycle N+1, ISSUE (`start`=1) cycle N+2.
- All outputs registered; none combinational from inputs.
- `reset` mid-ISSUE: next cycle all outputs at reset values; the instruction counts as issued only if `start` was already high before the reset edge.
- Written word readable by a fetch starting the cycle after `load_en`.

## Structure
- Package `sequencer_pkg`: state enum, `NOP_OPCODE` default, instruction field bit positions (OPC_MSB=11, OPC_LSB=8, OPR_MSB=7, OPR_LSB=0).
- Sub-module `program_memory`: 2^W x 12 register array, one synchronous write port, one synchronous read port.
- FSM, PC and output registers in the top.

## Test plan
- Reset, load addr 0..2 = 12'h1A5, 12'h2C3, 12'h300; `end_addr`=2, `run`=1 -> `start` at cycles 2, 4, 6 with opcode 1/2/3 and operand A5/C3/00; then `done`=1, `pc`=2.
- Same program, `loop`=1 -> after addr 2 issue, `pc`=0 and addr 0 reissued 2 cycles later; `done` stays 0.
- `run`=0, three `step` pulses 5 cycles apart -> exactly three `start` pulses, `pc` 0->1->2->3; opcode equals `NOP_OPCODE` between them.
- `run` dropped during FETCH of addr 1 -> addr 1 still issued, state IDLE, `pc`=2; `run` high again -> next issue is addr 2.
- `load_en` to addr 0 with data 12'hFFF while busy -> ignored; later halt/restart issues original addr 0 word.
- `reset` asserted in ISSUE -> next cycle `start`=0, `opcode`=`NOP_OPCODE`, `pc`=0, state IDLE; memory contents intact.
